// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - run-time programmable serial pattern detector with Mealy match strobe
// Optional saturating match counter compiled in when SEQDET_COUNT_EN is defined.
module seq_detect_param #(
    parameter int               PAT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = 8'b0001_0101,
    parameter int               RST_LEN = 5,
    parameter bit               RST_OVL = 1'b0,
    parameter int               CNT_W   = 16,
    localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic             match_q,
    output logic             cfg_err,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);

    logic [PAT_W-2:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic             cfg_err_q, cfg_err_d;

    logic [PAT_W-1:0] cand;
    logic [PAT_W-1:0] mask;
    logic             accept;
    logic             fill_ok;
    logic             cfg_ok;

    // Candidate window is the stored history plus the bit arriving now; mask keeps the low len bits.
    always_comb begin
        cand = {hist_q, din};
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign accept  = din_valid & ~cfg_load;
    assign fill_ok = (fill_q >= (len_q - LEN_W'(1)));
    assign match   = accept & fill_ok & (((cand ^ pat_q) & mask) == '0);
    assign cfg_ok  = (cfg_len != '0) && (cfg_len <= LEN_MAX);

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        cfg_err_d = cfg_load & ~cfg_ok;
        if (cfg_load) begin
            if (cfg_ok) begin
                pat_d  = cfg_pattern;
                len_d  = cfg_len;
                ovl_d  = cfg_overlap;
                fill_d = '0;
            end
        end else if (din_valid) begin
            hist_d = cand[PAT_W-2:0];
            // Non-overlap mode restarts the window so the next match needs len fresh bits.
            if (match && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= RST_PAT;
            len_q     <= LEN_W'(RST_LEN);
            ovl_q     <= RST_OVL;
            cfg_err_q <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            cfg_err_q <= cfg_err_d;
            match_q   <= match;
        end
    end

    assign cfg_err = cfg_err_q;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule
